// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_alu_dec.sv
// rtl/mc_control_unit_alu_dec.sv - aluop/funct to 3-bit ALU control decoder
import mc_pkg::*;

module mc_alu_dec (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       illegal_funct
);

    logic [2:0] fn_cont;

    // illegal_funct ignores aluop so DECODE can flag a bad R-type before it executes
    always_comb begin
        fn_cont       = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  fn_cont = ALU_ADD;
            FN_SUB:  fn_cont = ALU_SUB;
            FN_AND:  fn_cont = ALU_AND;
            FN_OR:   fn_cont = ALU_OR;
            FN_XOR:  fn_cont = ALU_XOR;
            FN_SLT:  fn_cont = ALU_SLT;
            FN_SRL:  fn_cont = ALU_SRL;
            FN_NOR:  fn_cont = ALU_ORN;
            default: illegal_funct = 1'b1;
        endcase

        case (aluop)
            ALUOP_SUB:   alucont = ALU_SUB;
            ALUOP_FUNCT: alucont = fn_cont;
            default:     alucont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS main FSM; MC_CONTROL_BNE_EN adds the bne path
import mc_pkg::*;

module mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucont,
    output logic       illegal
);

    state_t     state_q, state_d, cur;
    logic [1:0] aluop;
    logic       pcwrite, branch, nbranch;
    logic       illegal_funct;

    mc_alu_dec u_alu_dec (
        .aluop         (aluop),
        .funct         (funct),
        .alucont       (alucont),
        .illegal_funct (illegal_funct)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // during reset the non-enable outputs present the FETCH decode
        cur      = reset ? FETCH : state_q;
        state_d  = FETCH;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = SRCA_PC;
        alusrcb  = SRCB_RT;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        nbranch  = 1'b0;
        illegal  = 1'b0;

        case (cur)
            FETCH: begin
                irwrite = 1'b1;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH2;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE: begin
                        if (illegal_funct) illegal = 1'b1;
                        else               state_d = RTYPEEX;
                    end
                    OP_BEQ:  state_d = BEQEX;
                    OP_ADDI: state_d = ADDIEX;
                    OP_J:    state_d = JEX;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:  state_d = BNEEX;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = SRCA_RS;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = (funct == FN_SRL) ? SRCA_SHAMT : SRCA_RS;
                aluop   = ALUOP_FUNCT;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = SRCA_RS;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = SRCA_RS;
                alusrcb = SRCB_IMM;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
`ifdef MC_CONTROL_BNE_EN
            BNEEX: begin
                alusrca = SRCA_RS;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                nbranch = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase

        pcen = pcwrite | (branch & zero) | (nbranch & ~zero);
        if (reset) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed self-checking bench for mc_control_unit
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b000000;
    logic       zero = 1'b0;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;
    logic [1:0] alusrca, alusrcb, pcsrc;
    logic [2:0] alucont;
    int         n_checks = 0;
    int         n_fails = 0;

    // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucont,illegal}
    logic [16:0] outs;
    assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, alucont, illegal};

    localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_0_0_00_01_00_010_0;
    localparam logic [16:0] E_RST    = 17'b0_0_0_0_0_0_0_00_01_00_010_0;
    localparam logic [16:0] E_DEC    = 17'b0_0_0_0_0_0_0_00_11_00_010_0;
    localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_0_0_00_11_00_010_1;
    localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_01_10_00_010_0;
    localparam logic [16:0] E_MEMRD  = 17'b0_1_0_0_0_0_0_00_00_00_010_0;
    localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_1_1_00_00_00_010_0;
    localparam logic [16:0] E_MEMWR  = 17'b0_1_1_0_0_0_0_00_00_00_010_0;
    localparam logic [16:0] E_RWB    = 17'b0_0_0_0_1_0_1_00_00_00_010_0;
    localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_1_00_00_00_010_0;
    localparam logic [16:0] E_JEX    = 17'b1_0_0_0_0_0_0_00_00_10_010_0;
    localparam logic [16:0] E_BR0    = 17'b0_0_0_0_0_0_0_01_00_01_110_0;
    localparam logic [16:0] E_BR1    = 17'b1_0_0_0_0_0_0_01_00_01_110_0;

    mc_control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .pcen     (pcen),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .alucont  (alucont),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        op = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (outs !== E_RST) begin
                n_fails++;
                $display("FAIL reset_hold[%0d] actual=%b required=%b", i, outs, E_RST);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs !== E_FETCH) begin
            n_fails++;
            $display("FAIL reset_release actual=%b required=%b", outs, E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [16:0] ex [$];
        ex = '{E_FETCH, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        op = 6'b100011; funct = 6'b000000; zero = 1'b0;
        for (int i = 0; i < ex.size(); i++) begin
            if (i == 3) op = 6'b000000;
            #1;
            n_checks++;
            if (outs !== ex[i]) begin
                n_fails++;
                $display("FAIL lw_cycle%0d actual=%b required=%b", i, outs, ex[i]);
            end
            if (i < ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_sw_addi();
        logic [16:0] ex [$];
        ex = '{E_FETCH, E_DEC, E_MEMADR, E_MEMWR, E_FETCH,
               E_DEC, E_MEMADR, E_ADDIWB, E_FETCH};
        op = 6'b101011;
        for (int i = 0; i < ex.size(); i++) begin
            if (i == 4) op = 6'b001000;
            #1;
            n_checks++;
            if (outs !== ex[i]) begin
                n_fails++;
                $display("FAIL sw_addi_cycle%0d actual=%b required=%b", i, outs, ex[i]);
            end
            if (i < ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [8]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b101010, 6'b000010, 6'b100111};
        logic [2:0]  ac [8]  = '{3'b010, 3'b110, 3'b000, 3'b001,
                                 3'b011, 3'b111, 3'b100, 3'b101};
        logic [16:0] ex [$];
        logic [1:0]  sa;
        op = 6'b000000;
        for (int k = 0; k < 8; k++) begin
            funct = fn[k];
            sa = (k == 6) ? 2'b10 : 2'b01;
            ex = '{E_FETCH, E_DEC, {7'b0, sa, 2'b00, 2'b00, ac[k], 1'b0}, E_RWB, E_FETCH};
            for (int i = 0; i < ex.size(); i++) begin
                #1;
                n_checks++;
                if (outs !== ex[i]) begin
                    n_fails++;
                    $display("FAIL rtype_f%b_cycle%0d actual=%b required=%b", fn[k], i, outs, ex[i]);
                end
                if (i < ex.size() - 1) begin @(posedge clk); #1; end
            end
        end
        funct = 6'b111111;
        ex = '{E_FETCH, E_DECILL, E_FETCH};
        for (int i = 0; i < ex.size(); i++) begin
            #1;
            n_checks++;
            if (outs !== ex[i]) begin
                n_fails++;
                $display("FAIL rtype_badfunct_cycle%0d actual=%b required=%b", i, outs, ex[i]);
            end
            if (i < ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch(input logic [5:0] bop, input logic z, input logic [16:0] ex_br,
                               input logic enabled);
        logic [16:0] ex [$];
        if (enabled) ex = '{E_FETCH, E_DEC, ex_br, E_FETCH};
        else         ex = '{E_FETCH, E_DECILL, E_FETCH};
        op = bop; funct = 6'b000000; zero = z;
        for (int i = 0; i < ex.size(); i++) begin
            #1;
            n_checks++;
            if (outs !== ex[i]) begin
                n_fails++;
                $display("FAIL branch_op%b_z%0d_cycle%0d actual=%b required=%b", bop, z, i, outs, ex[i]);
            end
            if (i < ex.size() - 1) begin @(posedge clk); #1; end
        end
        zero = 1'b0;
    endtask

    task automatic test_j_illegal();
        logic [16:0] ex [$];
        ex = '{E_FETCH, E_DEC, E_JEX, E_FETCH, E_DECILL, E_FETCH};
        op = 6'b000010;
        for (int i = 0; i < ex.size(); i++) begin
            if (i == 3) op = 6'b111111;
            #1;
            n_checks++;
            if (outs !== ex[i]) begin
                n_fails++;
                $display("FAIL j_illegal_cycle%0d actual=%b required=%b", i, outs, ex[i]);
            end
            if (i < ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] ex [$];
        ex = '{E_FETCH, E_DEC, E_MEMADR, E_MEMRD, E_RST, E_RST, E_FETCH, E_DEC};
        op = 6'b100011;
        for (int i = 0; i < ex.size(); i++) begin
            if (i == 4) reset = 1'b1;
            if (i == 6) reset = 1'b0;
            #1;
            n_checks++;
            if (outs !== ex[i]) begin
                n_fails++;
                $display("FAIL mid_reset_cycle%0d actual=%b required=%b", i, outs, ex[i]);
            end
            if (i < ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_addi();
        test_rtype();
        test_branch(6'b000100, 1'b1, E_BR1, 1'b1);
        test_branch(6'b000100, 1'b0, E_BR0, 1'b1);
        test_j_illegal();
`ifdef MC_CONTROL_BNE_EN
        test_branch(6'b000101, 1'b0, E_BR1, 1'b1);
        test_branch(6'b000101, 1'b1, E_BR0, 1'b1);
`else
        test_branch(6'b000101, 1'b0, E_BR0, 1'b0);
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
